cordic_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined `cordic` core among `NUM_REQ` angle requesters. It owns the core's `angle` input and accepts at most one request per cycle. It saturates each angle to the core's convergence range and tracks in-flight slots in a tag pipeline matched to the core latency. It returns each `cos_val`/`sin_val` pair tagged with the requester index. It sits between the requesting datapath blocks and the single `cordic` instance.

---
 rtl/cordic_pkg.sv | 37 +++
 rtl/cordic_rr_sched_arb.sv | 37 +++
 rtl/cordic_rr_sched.sv | 93 +++++++++
 tb/tb_cordic_rr_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC round-robin scheduler.
// The angle clamp keeps every issued angle inside the core's convergence range.
package cordic_pkg;

  localparam int DW        = 8;
  localparam int REQ_COUNT = 4;
  localparam int ID_W      = $clog2(REQ_COUNT);

  localparam logic signed [DW-1:0] ANGLE_MAX = 8'sd100;
  localparam logic signed [DW-1:0] ANGLE_MIN = -8'sd100;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            sat;
  } sched_tag_t;

  typedef struct packed {
    logic [DW-1:0] angle;
    logic          sat;
  } sat_res_t;

  function automatic sat_res_t sat_angle(input logic signed [DW-1:0] a);
    sat_res_t r;
    r.angle = a;
    r.sat   = 1'b0;
    if (a > ANGLE_MAX) begin
      r.angle = ANGLE_MAX;
      r.sat   = 1'b1;
    end else if (a < ANGLE_MIN) begin
      r.angle = ANGLE_MIN;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_rr_sched_arb.sv
// Combinational round-robin arbiter: the first asserted request found by
// scanning cyclically upward from i_ptr wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_grant_idx,
  output logic               o_any
);

  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Shares one pipelined CORDIC core among NUM_REQ requesters, one accept per
// cycle, and returns each result tagged with the owning requester index.
module cordic_rr_sched
  import cordic_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int CORE_LAT   = 8,
  localparam int RID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_angle,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_core_angle,
  input  logic [DATA_WIDTH-1:0]         i_core_cos,
  input  logic [DATA_WIDTH-1:0]         i_core_sin,
  output logic                          o_rsp_valid,
  output logic [RID_W-1:0]              o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_cos,
  output logic [DATA_WIDTH-1:0]         o_rsp_sin,
  output logic                          o_rsp_sat
);

  logic [NUM_REQ-1:0]    w_grant;
  logic [RID_W-1:0]      w_grant_idx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_sel_angle;
  sat_res_t              w_sat;

  logic [RID_W-1:0]      r_ptr;
  logic [DATA_WIDTH-1:0] r_core_angle;
  logic                  r_rsp_valid;
  logic [RID_W-1:0]      r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_cos;
  logic [DATA_WIDTH-1:0] r_rsp_sin;
  logic                  r_rsp_sat;

  // Stage 0 sits beside r_core_angle; stages 1..CORE_LAT follow the core.
  sched_tag_t            r_tags [CORE_LAT+1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  always_comb begin
    w_sel_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_angle = i_req_angle[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_sat       = sat_angle(w_sel_angle);
  assign o_req_ready = rst ? '0 : w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_core_angle <= '0;
      for (int i = 0; i <= CORE_LAT; i++) r_tags[i] <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_cos    <= '0;
      r_rsp_sin    <= '0;
      r_rsp_sat    <= 1'b0;
    end else begin
      if (w_any) r_ptr <= (w_grant_idx == RID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      r_core_angle <= w_any ? w_sat.angle : '0;
      r_tags[0]    <= '{valid: w_any, id: ID_W'(w_grant_idx), sat: w_any & w_sat.sat};
      for (int i = 1; i <= CORE_LAT; i++) r_tags[i] <= r_tags[i-1];
      r_rsp_valid  <= r_tags[CORE_LAT].valid;
      r_rsp_id     <= RID_W'(r_tags[CORE_LAT].id);
      r_rsp_sat    <= r_tags[CORE_LAT].sat;
      if (r_tags[CORE_LAT].valid) begin
        r_rsp_cos <= i_core_cos;
        r_rsp_sin <= i_core_sin;
      end
    end
  end

  assign o_core_angle = r_core_angle;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_cos    = r_rsp_cos;
  assign o_rsp_sin    = r_rsp_sin;
  assign o_rsp_sat    = r_rsp_sat;

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed bench for cordic_rr_sched with a fixed-delay stand-in for the core
// that returns cos=angle+1 and sin=angle-1.
module tb_cordic_rr_sched;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int LAT = 8;

  typedef struct {
    int         idx;
    logic [7:0] angle;
    logic [7:0] expAngle;
    logic       expSat;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   reqValid;
  logic [NR*DW-1:0] reqAngle;
  logic [NR-1:0]   reqReady;
  logic [DW-1:0]   coreAngle, coreCos, coreSin;
  logic            rspValid;
  logic [1:0]      rspId;
  logic [DW-1:0]   rspCos, rspSin;
  logic            rspSat;
  logic [DW-1:0]   coreDly [LAT];

  int nVec  = 0;
  int nMiss = 0;
  vec_t vecs [8];

  cordic_rr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CORE_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (reqValid),
    .i_req_angle (reqAngle),
    .o_req_ready (reqReady),
    .o_core_angle(coreAngle),
    .i_core_cos  (coreCos),
    .i_core_sin  (coreSin),
    .o_rsp_valid (rspValid),
    .o_rsp_id    (rspId),
    .o_rsp_cos   (rspCos),
    .o_rsp_sin   (rspSin),
    .o_rsp_sat   (rspSat)
  );

  always #5 clk = ~clk;

  // Core stand-in: result appears LAT edges after the angle is presented.
  always @(posedge clk) begin
    coreDly[0] <= coreAngle;
    for (int i = 1; i < LAT; i++) coreDly[i] <= coreDly[i-1];
  end
  assign coreCos = coreDly[LAT-1] + 8'd1;
  assign coreSin = coreDly[LAT-1] - 8'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] angle, input logic on);
    reqAngle[idx*DW +: DW] = angle;
    reqValid[idx]          = on;
  endtask

  task automatic waitRsp(output int n);
    n = 0;
    while (rspValid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ready"}, 32'(reqReady), 0);
    checkOutput({tag, " core_angle"}, 32'(coreAngle), 0);
    checkOutput({tag, " rsp_valid"}, 32'(rspValid), 0);
    checkOutput({tag, " rsp_id"}, 32'(rspId), 0);
    checkOutput({tag, " rsp_cos"}, 32'(rspCos), 0);
    checkOutput({tag, " rsp_sin"}, 32'(rspSin), 0);
    checkOutput({tag, " rsp_sat"}, 32'(rspSat), 0);
  endtask

  task automatic singleReq(input string tag, input int idx, input logic [7:0] angle,
                           input logic [7:0] expAngle, input logic expSat);
    int n;
    logic [7:0] expCos, expSin;
    expCos = expAngle + 8'd1;
    expSin = expAngle - 8'd1;
    applyStimulus(idx, angle, 1'b1);
    #1;
    checkOutput({tag, " ready"}, 32'(reqReady), 32'(1 << idx));
    tick();
    applyStimulus(idx, angle, 1'b0);
    checkOutput({tag, " core_angle"}, 32'(coreAngle), 32'(expAngle));
    waitRsp(n);
    checkOutput({tag, " latency"}, 32'(n), LAT + 1);
    checkOutput({tag, " rsp_valid"}, 32'(rspValid), 1);
    checkOutput({tag, " rsp_id"}, 32'(rspId), 32'(idx));
    checkOutput({tag, " rsp_cos"}, 32'(rspCos), 32'(expCos));
    checkOutput({tag, " rsp_sin"}, 32'(rspSin), 32'(expSin));
    checkOutput({tag, " rsp_sat"}, 32'(rspSat), 32'(expSat));
    tick();
    checkOutput({tag, " rsp_valid pulse"}, 32'(rspValid), 0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int fairIds [6];
    vecs[0] = '{2, 8'h20, 8'h20, 1'b0};
    vecs[1] = '{1, 8'h7F, 8'h64, 1'b1};
    vecs[2] = '{0, 8'h80, 8'h9C, 1'b1};
    vecs[3] = '{3, 8'h64, 8'h64, 1'b0};
    vecs[4] = '{1, 8'h9C, 8'h9C, 1'b0};
    vecs[5] = '{0, 8'h65, 8'h64, 1'b1};
    vecs[6] = '{3, 8'h9B, 8'h9C, 1'b1};
    vecs[7] = '{2, 8'hF0, 8'hF0, 1'b0};
    fairIds = '{2, 3, 0, 1, 3, 0};

    rst      = 1'b0;
    reqValid = '0;
    reqAngle = '0;
    #1 rst   = 1'b1;
    reqValid = '1;
    #1;
    checkResetState("cold reset");
    tick();
    tick();
    rst      = 1'b0;
    reqValid = '0;

    // Single requests, including the clamp boundaries.
    for (int v = 0; v < 8; v++) begin
      singleReq($sformatf("vec%0d", v), vecs[v].idx, vecs[v].angle, vecs[v].expAngle, vecs[v].expSat);
    end

    // Fairness wrap: grant 2 alone so ptr sits at 3, then contend.
    applyStimulus(2, 8'h32, 1'b1);
    tick();
    applyStimulus(2, 8'h32, 1'b0);
    applyStimulus(0, 8'h30, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    #1 checkOutput("wrap grant 3", 32'(reqReady), 32'h8);
    tick();
    applyStimulus(3, 8'h33, 1'b0);
    #1 checkOutput("wrap grant 0", 32'(reqReady), 32'h1);
    tick();
    applyStimulus(0, 8'h30, 1'b0);
    applyStimulus(0, 8'h30, 1'b1);
    applyStimulus(1, 8'h31, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    #1 checkOutput("ptr at 1 grant", 32'(reqReady), 32'h2);
    tick();
    applyStimulus(1, 8'h31, 1'b0);
    #1 checkOutput("ptr at 2 grant", 32'(reqReady), 32'h8);
    tick();
    applyStimulus(3, 8'h33, 1'b0);
    #1 checkOutput("ptr at 0 grant", 32'(reqReady), 32'h1);
    tick();
    applyStimulus(0, 8'h30, 1'b0);
    waitRsp(n);
    checkOutput("wrap latency", 32'(n), 4);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("wrap rsp%0d valid", i), 32'(rspValid), 1);
      checkOutput($sformatf("wrap rsp%0d id", i), 32'(rspId), 32'(fairIds[i]));
      checkOutput($sformatf("wrap rsp%0d cos", i), 32'(rspCos), 32'(8'h31 + fairIds[i]));
      tick();
    end
    checkOutput("wrap drained", 32'(rspValid), 0);

    // All four requesters asserted from a fresh reset.
    pulseReset();
    for (int i = 0; i < NR; i++) applyStimulus(i, 8'(8'h10 + i), 1'b1);
    for (int c = 0; c < NR; c++) begin
      #1 checkOutput($sformatf("all4 grant%0d", c), 32'(reqReady), 32'(1 << c));
      tick();
      applyStimulus(c, 8'(8'h10 + c), 1'b0);
      checkOutput($sformatf("all4 core%0d", c), 32'(coreAngle), 32'(8'h10 + c));
    end
    waitRsp(n);
    checkOutput("all4 latency", 32'(n), 6);
    for (int c = 0; c < NR; c++) begin
      checkOutput($sformatf("all4 rsp%0d valid", c), 32'(rspValid), 1);
      checkOutput($sformatf("all4 rsp%0d id", c), 32'(rspId), 32'(c));
      checkOutput($sformatf("all4 rsp%0d cos", c), 32'(rspCos), 32'(8'h11 + c));
      checkOutput($sformatf("all4 rsp%0d sin", c), 32'(rspSin), 32'(8'h0F + c));
      tick();
    end
    checkOutput("all4 drained", 32'(rspValid), 0);

    // Reset while three results are still inside the core.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(c, 8'(8'h50 + c), 1'b1);
      tick();
      applyStimulus(c, 8'(8'h50 + c), 1'b0);
    end
    for (int i = 0; i < 3; i++) tick();
    rst      = 1'b1;
    reqValid = '1;
    #1 checkResetState("midflight reset");
    tick();
    rst      = 1'b0;
    reqValid = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rspValid === 1'b1) n++;
      tick();
    end
    checkOutput("stale results reported", 32'(n), 0);
    singleReq("post reset", 1, 8'h05, 8'h05, 1'b0);

    // Requests on alternate cycles.
    for (int c = 0; c < NR; c++) begin
      applyStimulus(c, 8'(8'h40 + c), 1'b1);
      tick();
      applyStimulus(c, 8'(8'h40 + c), 1'b0);
      checkOutput($sformatf("gap core%0d", c), 32'(coreAngle), 32'(8'h40 + c));
      tick();
      checkOutput($sformatf("gap idle core%0d", c), 32'(coreAngle), 0);
    end
    waitRsp(n);
    checkOutput("gap latency", 32'(n), 2);
    for (int c = 0; c < NR; c++) begin
      checkOutput($sformatf("gap rsp%0d valid", c), 32'(rspValid), 1);
      checkOutput($sformatf("gap rsp%0d id", c), 32'(rspId), 32'(c));
      checkOutput($sformatf("gap rsp%0d cos", c), 32'(rspCos), 32'(8'h41 + c));
      tick();
      checkOutput($sformatf("gap rsp%0d idle", c), 32'(rspValid), 0);
      checkOutput($sformatf("gap rsp%0d cos hold", c), 32'(rspCos), 32'(8'h41 + c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
